// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the accumulator ALU: buffers {opcode, operand} commands in a FIFO,
// issues one per result, captures result/error and clears the accumulator after any error.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic [WIDTH-1:0] alu_inputP_o,
  output logic [3:0]       alu_opCode_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic [1:0]       alu_error_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic [1:0]       res_error_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0] CntOne = 1;
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(DEPTH);
  localparam logic [3:0] OpClear = 4'b1100;
  localparam logic [3:0] OpNop = 4'b1110;

  typedef enum logic [2:0] {StClear, StIdle, StIssue, StHold, StFlush} state_e;

  state_e state_q, state_d;

  logic [WIDTH+3:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [1:0]       res_error_q;

  logic             empty, full, push, pop, flush, capture;
  logic [WIDTH+3:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);
  assign head  = mem_q[rd_ptr_q];

  assign cmd_ready_o = !full && (state_q != StClear) && (state_q != StFlush);
  assign push        = cmd_valid_i && cmd_ready_o;

  always_comb begin
    state_d      = state_q;
    alu_opCode_o = OpNop;
    alu_inputP_o = '0;
    pop          = 1'b0;
    flush        = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      StClear: begin
        alu_opCode_o = OpClear;
        state_d      = StIdle;
      end
      StIdle: begin
        if (!empty && !res_valid_q) state_d = StIssue;
      end
      StIssue: begin
        alu_opCode_o = head[WIDTH+3:WIDTH];
        alu_inputP_o = head[WIDTH-1:0];
        pop          = 1'b1;
        capture      = 1'b1;
        state_d      = (alu_error_i != 2'b00) ? StFlush : StHold;
      end
      StHold: begin
        if (res_valid_q && res_ready_i) state_d = empty ? StIdle : StIssue;
      end
      StFlush: begin
        flush = 1'b1;
        if (res_valid_q && res_ready_i) state_d = StClear;
      end
      default: state_d = StClear;
    endcase
    // Every edge under reset must zero the accumulator, whatever state we were in.
    if (rst_i) begin
      alu_opCode_o = OpClear;
      alu_inputP_o = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op_i, cmd_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop) begin
        count_q <= count_q + CntOne;
      end else if (pop && !push) begin
        count_q <= count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 2'b00;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_data_q  <= alu_result_i;
      res_error_q <= alu_error_i;
    end else if (res_valid_q && res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_error_o = res_error_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a small accumulator ALU model attached.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = 4'h0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] alu_inputP;
  logic [3:0]       alu_opCode;
  logic [WIDTH-1:0] alu_result;
  logic [1:0]       alu_error;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_error;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_data_i   (cmd_data),
    .alu_inputP_o (alu_inputP),
    .alu_opCode_o (alu_opCode),
    .alu_result_i (alu_result),
    .alu_error_i  (alu_error),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_error_o  (res_error)
  );

  // Accumulator ALU: add, divide, clear, all-ones; anything else holds.
  logic [WIDTH-1:0] acc = '0;
  logic [WIDTH:0]   sum;
  always_comb begin
    alu_result = acc;
    alu_error  = 2'b00;
    sum        = '0;
    case (alu_opCode)
      4'h0: begin
        sum        = {1'b0, acc} + {1'b0, alu_inputP};
        alu_result = sum[WIDTH-1:0];
        if (sum[WIDTH]) alu_error = 2'b10;
      end
      4'h3: begin
        if (alu_inputP == '0) alu_error = 2'b01;
        else alu_result = acc / alu_inputP;
      end
      4'hC: alu_result = '0;
      4'hD: alu_result = '1;
      default: ;
    endcase
  end
  always_ff @(posedge clk) acc <= alu_result;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Main stimulus works at negedge+1; the monitor samples at negedge+3.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [WIDTH-1:0] d, input bit resp,
                      input logic [WIDTH-1:0] ed, input logic [1:0] ee);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: cmd_ready stayed 0, expected 1");
    end else if (resp) begin
      exp_q.push_back('{data: ed, err: ee});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  // Monitor: pops on every accepted result and checks hold stability under backpressure.
  logic             hold_seen = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic [1:0]       hold_err;
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      hold_seen = 1'b0;
    end else begin
      if (hold_seen) begin
        check("res_stable", {res_valid, res_error, res_data}, {1'b1, hold_err, hold_data});
      end
      hold_seen = res_valid && !res_ready;
      hold_data = res_data;
      hold_err  = res_error;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got data 0x%0h err %0d, expected none",
                   res_data, res_error);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_error", res_error, e.err);
        end
      end
    end
  end

  initial begin
    // Reset and CLEAR
    repeat (2) tick();
    check("reset_opcode", alu_opCode, 4'hC);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_data", res_data, 0);
    check("reset_res_error", res_error, 0);
    rst = 1'b0;
    #1;
    check("clear_not_ready", cmd_ready, 0);
    tick();
    check("first_ready", cmd_ready, 1);
    check("idle_nop", alu_opCode, 4'hE);

    // Sequential adds with latency check
    cmd_valid = 1'b1;
    cmd_op    = 4'h0;
    cmd_data  = 5;
    exp_q.push_back('{data: 5, err: 2'b00});
    tick();
    check("lat_idle_nop", alu_opCode, 4'hE);
    check("lat_k1_valid", res_valid, 0);
    check("ready_second", cmd_ready, 1);
    cmd_data = 7;
    exp_q.push_back('{data: 12, err: 2'b00});
    tick();
    cmd_valid = 1'b0;
    check("issue_op", alu_opCode, 4'h0);
    check("issue_data", alu_inputP, 5);
    check("lat_k2_valid", res_valid, 0);
    tick();
    check("lat_valid", res_valid, 1);
    drain();

    // Divide by zero with queued commands behind it
    res_ready = 1'b0;
    push(4'h0, 0, 1'b1, 12, 2'b00);
    push(4'h3, 0, 1'b1, 12, 2'b01);
    push(4'h0, 9, 1'b0, 0, 2'b00);
    push(4'h0, 1, 1'b0, 0, 2'b00);
    tick();
    res_ready = 1'b1;
    drain();
    push(4'h0, 3, 1'b1, 3, 2'b00);
    drain();

    // Overflow
    push(4'hD, 0, 1'b1, 32'hFFFF_FFFF, 2'b00);
    push(4'h0, 1, 1'b1, 0, 2'b10);
    drain();

    // Backpressure fills the FIFO; sixth command waits for space
    res_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= DEPTH + 2; i++) push(4'h0, 1, 1'b1, WIDTH'(i), 2'b00);
      end
      begin
        repeat (12) tick();
        check("full_not_ready", cmd_ready, 0);
        check("stall_data", res_data, 1);
        check("stall_valid", res_valid, 1);
        res_ready = 1'b1;
      end
    join
    drain();

    // Push lands on the ISSUE pop cycle with three entries queued
    res_ready = 1'b0;
    for (int i = 7; i <= 10; i++) push(4'h0, 1, 1'b1, WIDTH'(i), 2'b00);
    tick();
    res_ready = 1'b1;
    tick();
    check("simul_issue_op", alu_opCode, 4'h0);
    check("simul_ready", cmd_ready, 1);
    push(4'h0, 1, 1'b1, 11, 2'b00);
    drain();

    // Reset mid-operation
    res_ready = 1'b0;
    for (int i = 12; i <= 15; i++) push(4'h0, 1, 1'b1, WIDTH'(i), 2'b00);
    tick();
    check("pre_reset_valid", res_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_reset_opcode", alu_opCode, 4'hC);
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("post_reset_valid", res_valid, 0);
    check("post_reset_not_ready", cmd_ready, 0);
    res_ready = 1'b1;
    tick();
    check("post_reset_ready", cmd_ready, 1);
    repeat (3) tick();
    check("fifo_empty_nop", alu_opCode, 4'hE);
    check("fifo_empty_valid", res_valid, 0);
    push(4'h0, 4, 1'b1, 4, 2'b00);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
